// File: rtl/pipe_pkg.sv
// Shared EX-stage definitions: data width, RV M-extension funct3 codes and
// the multiply/divide sequencer state type.
package pipe_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring
// divide share one 2*XLEN shift register and one iteration counter.
module ex_muldiv_unit #(
    parameter int XLEN = pipe_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);
    import pipe_pkg::*;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state_r;
    logic [2:0]      f3_r;
    logic            neg_r;
    logic [XLEN-1:0] opb_r;
    logic [2*XLEN-1:0] acc_r;
    logic [CW-1:0]   count_r;
    logic [4:0]      rd_r;

    logic            rs1_signed_s, rs2_signed_s, sign1_s, sign2_s, neg_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s, fast_res_s;
    logic            div_zero_s, ovf_s, fast_s;
    logic [XLEN:0]   add_s, shift_s, diff_s;
    logic [2*XLEN-1:0] step_s, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, final_s;

    assign rs1_signed_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                          (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign rs2_signed_s = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sign1_s = rs1_signed_s && rs1_data[XLEN-1];
    assign sign2_s = rs2_signed_s && rs2_data[XLEN-1];
    assign mag_a_s = sign1_s ? (ZERO - rs1_data) : rs1_data;
    assign mag_b_s = sign2_s ? (ZERO - rs2_data) : rs2_data;
    // Remainder takes the dividend's sign; products and quotients the XOR.
    assign neg_s   = (funct3 == F3_REM) ? sign1_s : (sign1_s ^ sign2_s);

    assign div_zero_s = funct3[2] && (rs2_data == ZERO);
    assign ovf_s      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                        (rs1_data == MINV) && (rs2_data == ONES);
    assign fast_s     = div_zero_s || ovf_s;

    // Architected results for divide-by-zero and signed overflow.
    always_comb begin
        fast_res_s = ZERO;
        if (div_zero_s) begin
            fast_res_s = funct3[1] ? rs1_data : ONES;
        end else if (ovf_s) begin
            fast_res_s = funct3[1] ? ZERO : MINV;
        end else begin
            fast_res_s = ZERO;
        end
    end

    assign add_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                     (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    assign shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign diff_s  = shift_s - {1'b0, opb_r};

    // One iteration: divide shifts a quotient bit in, multiply shifts the sum right.
    always_comb begin
        step_s = acc_r;
        if (f3_r[2]) begin
            if (diff_s[XLEN]) begin
                step_s = {shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            step_s = {add_s, acc_r[XLEN-1:1]};
        end
    end

    assign prod_s = neg_r ? ({(2*XLEN){1'b0}} - step_s) : step_s;
    assign quo_s  = neg_r ? (ZERO - step_s[XLEN-1:0]) : step_s[XLEN-1:0];
    assign rem_s  = neg_r ? (ZERO - step_s[2*XLEN-1:XLEN]) : step_s[2*XLEN-1:XLEN];

    // Final value selection from the last iteration's register contents.
    always_comb begin
        final_s = ZERO;
        if (f3_r[2]) begin
            final_s = f3_r[1] ? rem_s : quo_s;
        end else if (f3_r == F3_MUL) begin
            final_s = prod_s[XLEN-1:0];
        end else begin
            final_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    assign stall = start && (state_r != DONE) && !flush;
    assign busy  = (state_r != IDLE);

    // Sequencer: accept, iterate, present result; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            f3_r         <= 3'd0;
            neg_r        <= 1'b0;
            opb_r        <= ZERO;
            acc_r        <= {(2*XLEN){1'b0}};
            count_r      <= {CW{1'b0}};
            rd_r         <= 5'd0;
            result       <= ZERO;
            rd_out       <= 5'd0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (flush) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            f3_r    <= funct3;
                            neg_r   <= neg_s;
                            opb_r   <= mag_b_s;
                            acc_r   <= {ZERO, mag_a_s};
                            count_r <= CW'(XLEN);
                            rd_r    <= rd_in;
                            if (fast_s) begin
                                result       <= fast_res_s;
                                rd_out       <= rd_in;
                                result_valid <= 1'b1;
                                state_r      <= DONE;
                            end else begin
                                state_r <= BUSY;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    BUSY: begin
                        acc_r   <= step_s;
                        count_r <= count_r - CW'(1);
                        if (count_r == CW'(1)) begin
                            result       <= final_s;
                            rd_out       <= rd_r;
                            result_valid <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                    DONE:    state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic reference model, scoreboard
// queue of expected results and a per-cycle output compare process.
module tb_ex_muldiv_unit;
    import pipe_pkg::*;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] rs1_data = 64'd0;
    logic [63:0] rs2_data = 64'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        stall, result_valid, busy;
    logic [63:0] result;
    logic [4:0]  rd_out;

    ex_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .stall(stall),
        .result_valid(result_valid), .result(result), .rd_out(rd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;
    exp_t q[$];
    logic [63:0] last_res = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic [127:0]        pu;
        logic signed [63:0]  sa, sb, sr;
        logic [63:0]         r;
        sa = a;
        sb = b;
        r  = 64'd0;
        case (f)
            F3_MUL:    begin pu = {64'd0, a} * {64'd0, b}; r = pu[63:0]; end
            F3_MULH:   begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
            F3_MULHSU: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
            F3_MULHU:  begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
            F3_DIV: begin
                if (b == 64'd0) r = ONES;
                else if (a == MINV && b == ONES) r = MINV;
                else begin sr = sa / sb; r = sr; end
            end
            F3_DIVU: r = (b == 64'd0) ? ONES : a / b;
            F3_REM: begin
                if (b == 64'd0) r = a;
                else if (a == MINV && b == ONES) r = 64'd0;
                else begin sr = sa % sb; r = sr; end
            end
            F3_REMU: r = (b == 64'd0) ? a : a % b;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        if (f[2] && (b == 64'd0 || ((f == F3_DIV || f == F3_REM) && a == MINV && b == ONES)))
            return 1;
        return 65;
    endfunction

    // Per-cycle output compare against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) last_res = 64'd0;
        if (result_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got result_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check64("result", result, e.res);
                check64("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                check_int("pulse_cycle", cyc, e.at);
                last_res = e.res;
            end
        end else begin
            check64("result_hold", result, last_res);
        end
    end

    task automatic drive_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd);
        exp_t e;
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        e.res    = model(f, a, b);
        e.rd     = rd;
        e.at     = cyc + model_lat(f, a, b);
        q.push_back(e);
    endtask

    // Count stall cycles until the pulse (bounded), then release start.
    task automatic wait_op(input int lat);
        int n_stall = 0;
        int k = 0;
        while (!result_valid && k < 200) begin
            if (stall) n_stall++;
            k++;
            @(negedge clk);
            #2;
        end
        check_int("pulse_seen", int'(result_valid), 1);
        check_int("stall_in_done", int'(stall), 0);
        check_int("busy_in_done", int'(busy), 1);
        check_int("stall_cycles", n_stall, lat);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        @(negedge clk);
        drive_op(f, a, b, rd);
        #2;
        wait_op(model_lat(f, a, b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Pin the reference model with hand-computed values.
        check64("model_mul",    model(F3_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        check64("model_mulh",   model(F3_MULH, MINV, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("model_mulhsu", model(F3_MULHSU, MINV, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("model_mulhu",  model(F3_MULHU, MINV, 64'd2), 64'h0000_0000_0000_0001);
        check64("model_div",    model(F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check64("model_rem",    model(F3_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("model_divu",   model(F3_DIVU, 64'd100, 64'd7), 64'd14);
        check64("model_remu",   model(F3_REMU, 64'd100, 64'd7), 64'd2);
        check64("model_div0",   model(F3_DIV, 64'd5, 64'd0), ONES);
        check64("model_rem_ovf", model(F3_REM, MINV, ONES), 64'd0);

        repeat (2) @(negedge clk);
        #2;
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_valid", int'(result_valid), 0);
        check64("rst_result", result, 64'd0);
        check64("rst_rd", {59'd0, rd_out}, 64'd0);
        check_int("rst_stall", int'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(F3_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        run_op(F3_MULH,   MINV, 64'd2, 5'd6);
        run_op(F3_MULHSU, MINV, 64'd2, 5'd7);
        run_op(F3_MULHU,  MINV, 64'd2, 5'd8);
        run_op(F3_MULHU,  ONES, ONES, 5'd9);
        run_op(F3_MULH,   64'hFFFF_FFFF_FFFF_FFFD, 64'h1234_5678_9ABC_DEF0, 5'd10);
        run_op(F3_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11);
        run_op(F3_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12);
        run_op(F3_DIVU,   64'd100, 64'd7, 5'd13);
        run_op(F3_REMU,   64'd100, 64'd7, 5'd14);
        run_op(F3_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd15);
        run_op(F3_DIVU,   ONES, 64'd3, 5'd16);
        run_op(F3_DIV,    64'd5, 64'd0, 5'd17);
        run_op(F3_REMU,   64'd5, 64'd0, 5'd18);
        run_op(F3_DIV,    MINV, ONES, 5'd19);
        run_op(F3_REM,    MINV, ONES, 5'd20);

        // Flush at BUSY cycle 30, then an immediate second op.
        run_op(F3_DIVU, 64'd100, 64'd7, 5'd3);
        @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; rs1_data = 64'd123; rs2_data = 64'd456; rd_in = 5'd9;
        repeat (30) @(negedge clk);
        flush = 1'b1;
        #2;
        check_int("flush_stall", int'(stall), 0);
        check_int("flush_busy_before", int'(busy), 1);
        @(negedge clk);
        flush = 1'b0;
        drive_op(F3_REMU, 64'd1000, 64'd33, 5'd21);
        #2;
        check_int("flush_busy_after", int'(busy), 0);
        check64("flush_rd_kept", {59'd0, rd_out}, 64'd3);
        wait_op(65);

        // Reset at BUSY cycle 10, then release with start held.
        @(negedge clk);
        start = 1'b1; funct3 = F3_REMU; rs1_data = 64'd999; rs2_data = 64'd10; rd_in = 5'd4;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_int("rstmid_busy", int'(busy), 0);
        check_int("rstmid_valid", int'(result_valid), 0);
        check64("rstmid_result", result, 64'd0);
        check_int("rstmid_stall", int'(stall), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_op(F3_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        #2;
        wait_op(65);

        repeat (3) @(negedge clk);
        #3;
        check_int("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
